// File: rtl/h2c_dsc_bypass_ctrl_pkg.sv
// Shared XDMA descriptor-bypass definitions for the H2C and C2H bypass controllers.
package h2c_dsc_bypass_ctrl_pkg;

    localparam int DSC_ADDR_W = 64;
    localparam int DSC_LEN_W  = 28;
    localparam int DSC_CTL_W  = 16;

    localparam logic [DSC_CTL_W-1:0] DSC_CTL_EOP = 16'h0001;

    // Host address of ring buffer idx: base + idx * len.
    function automatic logic [DSC_ADDR_W-1:0] dsc_buf_addr(
        input logic [DSC_ADDR_W-1:0] base,
        input logic [DSC_LEN_W-1:0]  len,
        input logic [31:0]           idx
    );
        return base + (64'(idx) * 64'(len));
    endfunction

endpackage

// File: rtl/h2c_dsc_bypass_ctrl_keep_popcount.sv
// Combinational population count of an AXI-Stream tkeep vector.
module keep_popcount #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] keep,
    output logic [CNT_W-1:0] count
);

    // Sum the set bits of keep.
    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + CNT_W'(keep[i]);
        end
    end

endmodule

// File: rtl/h2c_dsc_bypass_ctrl.sv
// H2C descriptor-bypass controller: issues fixed-size ring-buffer descriptors to XDMA
// and monitors the returned stream for completions, length and protocol errors.
module h2c_dsc_bypass_ctrl
    import h2c_dsc_bypass_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 256,
    parameter logic [DSC_ADDR_W-1:0] HOST_BASE_ADDR  = 64'h0000_0001_0000_0000,
    parameter logic [DSC_LEN_W-1:0]  BUF_LEN         = 28'h000_1000,
    parameter int                    NR_BUFS         = 16,
    parameter int                    MAX_OUTSTANDING = 4
) (
    input  logic                    user_clk,
    input  logic                    user_rst,
    input  logic                    enable,
    input  logic                    user_lnk_up,
    input  logic                    dsc_byp_ready,
    output logic                    dsc_byp_load,
    output logic [DSC_ADDR_W-1:0]   dsc_byp_src_addr,
    output logic [DSC_ADDR_W-1:0]   dsc_byp_dst_addr,
    output logic [DSC_LEN_W-1:0]    dsc_byp_len,
    output logic [DSC_CTL_W-1:0]    dsc_byp_ctl,
    input  logic                    h2c_tvalid,
    output logic                    h2c_tready,
    input  logic [DATA_WIDTH-1:0]   h2c_tdata,
    input  logic [DATA_WIDTH/8-1:0] h2c_tkeep,
    input  logic                    h2c_tlast,
    output logic                    out_tvalid,
    input  logic                    out_tready,
    output logic [DATA_WIDTH-1:0]   out_tdata,
    output logic [DATA_WIDTH/8-1:0] out_tkeep,
    output logic                    out_tlast,
    output logic [2:0]              outstanding,
    output logic [31:0]             nr_completed,
    output logic                    len_err,
    output logic                    proto_err
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int POP_W  = $clog2(KEEP_W) + 1;
    localparam int IDX_W  = (NR_BUFS > 1) ? $clog2(NR_BUFS) : 1;
    localparam int CNT_W  = DSC_LEN_W + 1;
    localparam int SUM_W  = CNT_W + 1;
    localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

    logic                  load_r;
    logic [IDX_W-1:0]      idx_r;
    logic [DSC_ADDR_W-1:0] src_addr_r;
    logic [2:0]            outstanding_r;
    logic [CNT_W-1:0]      byte_cnt_r;
    logic [31:0]           nr_completed_r;
    logic                  len_err_r;
    logic                  proto_err_r;

    logic [POP_W-1:0]      pop_s;
    logic                  accept_s;
    logic                  beat_s;
    logic                  done_s;
    logic                  proto_s;
    logic [SUM_W-1:0]      byte_sum_s;
    logic [CNT_W-1:0]      byte_total_s;
    logic [2:0]            outstanding_nxt_s;
    logic [IDX_W-1:0]      idx_nxt_s;
    logic                  load_nxt_s;

    keep_popcount #(
        .WIDTH (KEEP_W),
        .CNT_W (POP_W)
    ) u_keep_popcount (
        .keep  (h2c_tkeep),
        .count (pop_s)
    );

    assign out_tvalid = h2c_tvalid;
    assign out_tdata  = h2c_tdata;
    assign out_tkeep  = h2c_tkeep;
    assign out_tlast  = h2c_tlast;
    assign h2c_tready = out_tready;

    // Handshake decode, saturating byte total and next-state for the issue/credit logic.
    always_comb begin
        accept_s   = load_r & dsc_byp_ready;
        beat_s     = h2c_tvalid & out_tready;
        done_s     = beat_s & h2c_tlast;
        proto_s    = 1'b0;
        byte_sum_s = {1'b0, byte_cnt_r} + SUM_W'(pop_s);
        if (byte_sum_s[CNT_W]) begin
            byte_total_s = {CNT_W{1'b1}};
        end else begin
            byte_total_s = byte_sum_s[CNT_W-1:0];
        end
        case ({accept_s, done_s})
            2'b10:   outstanding_nxt_s = outstanding_r + 3'd1;
            2'b01: begin
                if (outstanding_r == 3'd0) begin
                    outstanding_nxt_s = 3'd0;
                    proto_s           = 1'b1;
                end else begin
                    outstanding_nxt_s = outstanding_r - 3'd1;
                end
            end
            default: outstanding_nxt_s = outstanding_r;
        endcase
        if (accept_s) begin
            idx_nxt_s = idx_r + IDX_W'(1);
        end else begin
            idx_nxt_s = idx_r;
        end
        // A raised load holds until taken; a new one needs a free credit after this cycle.
        load_nxt_s = (load_r & ~dsc_byp_ready)
                   | (enable & user_lnk_up & (outstanding_nxt_s < MAX_OUT));
    end

    // State registers with synchronous reset.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            load_r         <= 1'b0;
            idx_r          <= '0;
            src_addr_r     <= HOST_BASE_ADDR;
            outstanding_r  <= 3'd0;
            byte_cnt_r     <= '0;
            nr_completed_r <= 32'd0;
            len_err_r      <= 1'b0;
            proto_err_r    <= 1'b0;
        end else begin
            load_r        <= load_nxt_s;
            idx_r         <= idx_nxt_s;
            src_addr_r    <= dsc_buf_addr(HOST_BASE_ADDR, BUF_LEN, 32'(idx_nxt_s));
            outstanding_r <= outstanding_nxt_s;
            if (done_s) begin
                byte_cnt_r     <= '0;
                nr_completed_r <= nr_completed_r + 32'd1;
            end else if (beat_s) begin
                byte_cnt_r <= byte_total_s;
            end
            if (done_s && (byte_total_s != {1'b0, BUF_LEN})) begin
                len_err_r <= 1'b1;
            end
            if (proto_s) begin
                proto_err_r <= 1'b1;
            end
        end
    end

    assign dsc_byp_load     = load_r;
    assign dsc_byp_src_addr = src_addr_r;
    assign dsc_byp_dst_addr = {DSC_ADDR_W{1'b0}};
    assign dsc_byp_len      = BUF_LEN;
    assign dsc_byp_ctl      = DSC_CTL_EOP;
    assign outstanding      = outstanding_r;
    assign nr_completed     = nr_completed_r;
    assign len_err          = len_err_r;
    assign proto_err        = proto_err_r;

endmodule

// File: tb/tb_h2c_dsc_bypass_ctrl.sv
// Directed self-checking bench for h2c_dsc_bypass_ctrl with default parameters.
module tb_h2c_dsc_bypass_ctrl;

    localparam logic [63:0] BASE = 64'h0000_0001_0000_0000;
    localparam logic [63:0] STEP = 64'h0000_0000_0000_1000;

    logic         user_clk;
    logic         user_rst;
    logic         enable;
    logic         user_lnk_up;
    logic         dsc_byp_ready;
    logic         dsc_byp_load;
    logic [63:0]  dsc_byp_src_addr;
    logic [63:0]  dsc_byp_dst_addr;
    logic [27:0]  dsc_byp_len;
    logic [15:0]  dsc_byp_ctl;
    logic         h2c_tvalid;
    logic         h2c_tready;
    logic [255:0] h2c_tdata;
    logic [31:0]  h2c_tkeep;
    logic         h2c_tlast;
    logic         out_tvalid;
    logic         out_tready;
    logic [255:0] out_tdata;
    logic [31:0]  out_tkeep;
    logic         out_tlast;
    logic [2:0]   outstanding;
    logic [31:0]  nr_completed;
    logic         len_err;
    logic         proto_err;

    int n_checks;
    int n_fail;
    int acc_total;

    h2c_dsc_bypass_ctrl dut (
        .user_clk         (user_clk),
        .user_rst         (user_rst),
        .enable           (enable),
        .user_lnk_up      (user_lnk_up),
        .dsc_byp_ready    (dsc_byp_ready),
        .dsc_byp_load     (dsc_byp_load),
        .dsc_byp_src_addr (dsc_byp_src_addr),
        .dsc_byp_dst_addr (dsc_byp_dst_addr),
        .dsc_byp_len      (dsc_byp_len),
        .dsc_byp_ctl      (dsc_byp_ctl),
        .h2c_tvalid       (h2c_tvalid),
        .h2c_tready       (h2c_tready),
        .h2c_tdata        (h2c_tdata),
        .h2c_tkeep        (h2c_tkeep),
        .h2c_tlast        (h2c_tlast),
        .out_tvalid       (out_tvalid),
        .out_tready       (out_tready),
        .out_tdata        (out_tdata),
        .out_tkeep        (out_tkeep),
        .out_tlast        (out_tlast),
        .outstanding      (outstanding),
        .nr_completed     (nr_completed),
        .len_err          (len_err),
        .proto_err        (proto_err)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    task automatic step();
        @(negedge user_clk);
    endtask

    task automatic send_packet(input int beats, input logic [31:0] last_keep);
        for (int b = 0; b < beats; b++) begin
            h2c_tvalid = 1'b1;
            h2c_tlast  = (b == beats - 1);
            h2c_tkeep  = (b == beats - 1) ? last_keep : 32'hFFFF_FFFF;
            h2c_tdata  = {8{32'(b)}};
            step();
        end
        h2c_tvalid = 1'b0;
        h2c_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        user_rst = 1'b1; enable = 1'b0; user_lnk_up = 1'b0; dsc_byp_ready = 1'b0;
        h2c_tvalid = 1'b0; h2c_tlast = 1'b0; h2c_tkeep = 32'h0; h2c_tdata = 256'h0;
        out_tready = 1'b1;
        repeat (3) step();
        n_checks++; if (dsc_byp_load !== 1'b0) begin n_fail++; $display("FAIL rst_load: got %b want 0", dsc_byp_load); end
        n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL rst_outstanding: got %0d want 0", outstanding); end
        n_checks++; if (nr_completed !== 32'd0) begin n_fail++; $display("FAIL rst_nr_completed: got %0d want 0", nr_completed); end
        n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL rst_len_err: got %b want 0", len_err); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rst_proto_err: got %b want 0", proto_err); end
        h2c_tdata  = {64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_F0E1_D2C3, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
        h2c_tkeep  = 32'hA5A5_0F0F;
        h2c_tlast  = 1'b1;
        h2c_tvalid = 1'b1;
        out_tready = 1'b0;
        #1;
        n_checks++; if (out_tdata !== {64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_F0E1_D2C3, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888})
            begin n_fail++; $display("FAIL pass_tdata: got %h", out_tdata); end
        n_checks++; if (out_tkeep !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL pass_tkeep: got %h want a5a50f0f", out_tkeep); end
        n_checks++; if ({out_tvalid, out_tlast, h2c_tready} !== 3'b110) begin n_fail++; $display("FAIL pass_ctrl: got %b want 110", {out_tvalid, out_tlast, h2c_tready}); end
        out_tready = 1'b1;
        #1;
        n_checks++; if (h2c_tready !== 1'b1) begin n_fail++; $display("FAIL pass_tready: got %b want 1", h2c_tready); end
        h2c_tvalid = 1'b0; h2c_tlast = 1'b0; h2c_tkeep = 32'h0;
        step();
        user_rst = 1'b0;
    endtask

    task automatic test_issue();
        int n;
        n = 0;
        enable = 1'b1; user_lnk_up = 1'b1; dsc_byp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (dsc_byp_load && dsc_byp_ready) begin
                n_checks++;
                if (dsc_byp_src_addr !== BASE + 64'(acc_total % 16) * STEP) begin
                    n_fail++; $display("FAIL issue_addr: got %h want %h", dsc_byp_src_addr, BASE + 64'(acc_total % 16) * STEP);
                end
                if (n == 0) begin
                    n_checks++;
                    if ({dsc_byp_dst_addr, dsc_byp_len, dsc_byp_ctl} !== {64'h0, 28'h000_1000, 16'h0001}) begin
                        n_fail++; $display("FAIL issue_fields: dst %h len %h ctl %h want 0 1000 0001", dsc_byp_dst_addr, dsc_byp_len, dsc_byp_ctl);
                    end
                end
                acc_total++;
                n++;
            end
            step();
        end
        n_checks++; if (n != 4) begin n_fail++; $display("FAIL issue_count: got %0d want 4", n); end
        n_checks++; if (dsc_byp_load !== 1'b0) begin n_fail++; $display("FAIL issue_load_off: got %b want 0", dsc_byp_load); end
        n_checks++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL issue_outstanding: got %0d want 4", outstanding); end
    endtask

    task automatic test_completion();
        dsc_byp_ready = 1'b0;
        for (int b = 0; b < 128; b++) begin
            h2c_tvalid = 1'b1;
            h2c_tlast  = (b == 127);
            h2c_tkeep  = 32'hFFFF_FFFF;
            h2c_tdata  = {8{32'(b)}};
            if (b == 127) begin
                n_checks++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL cmpl_pre_outstanding: got %0d want 4", outstanding); end
            end
            step();
        end
        h2c_tvalid = 1'b0; h2c_tlast = 1'b0;
        n_checks++; if (nr_completed !== 32'd1) begin n_fail++; $display("FAIL cmpl_count: got %0d want 1", nr_completed); end
        n_checks++; if (outstanding !== 3'd3) begin n_fail++; $display("FAIL cmpl_outstanding: got %0d want 3", outstanding); end
        n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL cmpl_len_err: got %b want 0", len_err); end
        n_checks++; if (dsc_byp_load !== 1'b1) begin n_fail++; $display("FAIL cmpl_load_rise: got %b want 1", dsc_byp_load); end
        n_checks++; if (dsc_byp_src_addr !== 64'h0000_0001_0000_4000) begin n_fail++; $display("FAIL cmpl_next_addr: got %h want 100004000", dsc_byp_src_addr); end
    endtask

    task automatic test_ready_stall();
        int n;
        n = 0;
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({dsc_byp_load, dsc_byp_src_addr} !== {1'b1, 64'h0000_0001_0000_4000}) begin
                n_fail++; $display("FAIL stall_hold: load %b addr %h want 1 100004000", dsc_byp_load, dsc_byp_src_addr);
            end
            step();
        end
        dsc_byp_ready = 1'b1;
        if (dsc_byp_load && dsc_byp_ready) begin acc_total++; n++; end
        step();
        dsc_byp_ready = 1'b0;
        n_checks++; if (n != 1) begin n_fail++; $display("FAIL stall_accept: got %0d want 1", n); end
        n_checks++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL stall_outstanding: got %0d want 4", outstanding); end
        n_checks++; if (dsc_byp_load !== 1'b0) begin n_fail++; $display("FAIL stall_load_off: got %b want 0", dsc_byp_load); end
    endtask

    task automatic test_len_err();
        enable = 1'b0; dsc_byp_ready = 1'b0;
        send_packet(128, 32'h0000_FFFF);
        n_checks++; if (len_err !== 1'b1) begin n_fail++; $display("FAIL len_err_set: got %b want 1", len_err); end
        n_checks++; if (nr_completed !== 32'd2) begin n_fail++; $display("FAIL len_err_count: got %0d want 2", nr_completed); end
        n_checks++; if (outstanding !== 3'd3) begin n_fail++; $display("FAIL len_err_outstanding: got %0d want 3", outstanding); end
        n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL len_err_proto: got %b want 0", proto_err); end
    endtask

    task automatic test_back_to_back_wrap();
        enable = 1'b1; dsc_byp_ready = 1'b1;
        h2c_tvalid = 1'b1; h2c_tlast = 1'b1; h2c_tkeep = 32'hFFFF_FFFF;
        for (int i = 0; i < 60 && acc_total < 17; i++) begin
            if (dsc_byp_load && dsc_byp_ready) begin
                n_checks++;
                if (acc_total == 16) begin
                    if (dsc_byp_src_addr !== BASE) begin n_fail++; $display("FAIL wrap_addr17: got %h want 100000000", dsc_byp_src_addr); end
                end else if (dsc_byp_src_addr !== BASE + 64'(acc_total % 16) * STEP) begin
                    n_fail++; $display("FAIL wrap_addr: got %h want %h", dsc_byp_src_addr, BASE + 64'(acc_total % 16) * STEP);
                end
                acc_total++;
            end
            step();
        end
        h2c_tvalid = 1'b0; h2c_tlast = 1'b0; enable = 1'b0; dsc_byp_ready = 1'b0;
        n_checks++; if (acc_total != 17) begin n_fail++; $display("FAIL wrap_count: got %0d want 17", acc_total); end
        n_checks++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL wrap_outstanding: got %0d want 2", outstanding); end
    endtask

    task automatic test_proto_err();
        h2c_tvalid = 1'b1; h2c_tlast = 1'b1; h2c_tkeep = 32'hFFFF_FFFF;
        step();
        step();
        h2c_tvalid = 1'b0;
        n_checks++; if ({outstanding, proto_err} !== {3'd0, 1'b0}) begin n_fail++; $display("FAIL proto_drain: out %0d proto %b want 0 0", outstanding, proto_err); end
        h2c_tvalid = 1'b1;
        step();
        h2c_tvalid = 1'b0; h2c_tlast = 1'b0;
        n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_set: got %b want 1", proto_err); end
        n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL proto_outstanding: got %0d want 0", outstanding); end
    endtask

    task automatic test_reset_mid();
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        enable = 1'b1; dsc_byp_ready = 1'b1;
        for (int i = 0; i < 20 && n < 2; i++) begin
            if (dsc_byp_load && dsc_byp_ready) begin
                n++;
                if (n == 2) enable = 1'b0;
            end
            step();
        end
        dsc_byp_ready = 1'b0;
        n_checks++; if (outstanding !== 3'd2) begin n_fail++; $display("FAIL mid_pre_outstanding: got %0d want 2", outstanding); end
        h2c_tvalid = 1'b1; h2c_tlast = 1'b0; h2c_tkeep = 32'hFFFF_FFFF;
        repeat (10) step();
        user_rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({dsc_byp_load, outstanding, nr_completed, len_err, proto_err} !== 37'd0) begin
            n_fail++; $display("FAIL mid_rst_status: load %b out %0d cmpl %0d len %b proto %b want all 0",
                               dsc_byp_load, outstanding, nr_completed, len_err, proto_err);
        end
        user_rst = 1'b0; h2c_tvalid = 1'b0; enable = 1'b1; dsc_byp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (dsc_byp_load && dsc_byp_ready) begin
                got = 1'b1;
                n_checks++;
                if (dsc_byp_src_addr !== BASE) begin n_fail++; $display("FAIL mid_first_addr: got %h want 100000000", dsc_byp_src_addr); end
                break;
            end
            step();
        end
        n_checks++; if (!got) begin n_fail++; $display("FAIL mid_load_timeout: got no load want one within 10 cycles"); end
        step();
        enable = 1'b0; dsc_byp_ready = 1'b0;
        n_checks++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL mid_post_outstanding: got %0d want 1", outstanding); end
        send_packet(128, 32'hFFFF_FFFF);
        n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL mid_clean_len: got %b want 0", len_err); end
        n_checks++; if (nr_completed !== 32'd1) begin n_fail++; $display("FAIL mid_clean_count: got %0d want 1", nr_completed); end
        n_checks++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL mid_clean_outstanding: got %0d want 0", outstanding); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        acc_total = 0;
        test_reset();
        test_issue();
        test_completion();
        test_ready_stall();
        test_len_err();
        test_back_to_back_wrap();
        test_proto_err();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
